ro_puf_ctrl: RTL

- Synchronous measurement controller for a ring-oscillator PUF array with NUM_RO oscillators.
- Each bit: selects an oscillator pair from the challenge, counts edges of both over a fixed clk window, compares counts, shifts one response bit into a RESP_BITS-wide response.
- Sits between the free-running oscillator bank (external, pre-divided so each osc_in toggles below clk/4) and the chip output pins.

---
 rtl/ro_puf_ctrl_pkg.sv | 18 +
 rtl/ro_puf_ctrl_if.sv | 30 +++
 rtl/ro_puf_ctrl_edge_counter.sv | 24 ++
 rtl/ro_puf_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_ctrl_pkg.sv
// Shared types for the ring-oscillator PUF controller: FSM state encoding
// and a width helper for index/timer registers.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COUNT   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } puf_state_e;

    // Bits needed to hold the values 0 .. n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_puf_ctrl_if.sv
// Request/response bus of ro_puf_ctrl. PUF_MARGIN_EN adds the unstable mask.
// start is a single-cycle request with no ready: it is taken only when busy
// is low, otherwise dropped; resp_valid is a single-cycle pulse, response/err
// (and unstable) stay stable until the next pulse.
interface ro_puf_ctrl_if #(
    parameter int SEL_W     = 5,
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [SEL_W-1:0]     chal_a;
    logic [SEL_W-1:0]     chal_b;
    logic                 ro_en;
    logic                 busy;
    logic                 resp_valid;
    logic [RESP_BITS-1:0] response;
    logic                 err;
`ifdef PUF_MARGIN_EN
    logic [RESP_BITS-1:0] unstable;

    modport master (output start, chal_a, chal_b,
                    input  ro_en, busy, resp_valid, response, err, unstable);
    modport slave  (input  start, chal_a, chal_b,
                    output ro_en, busy, resp_valid, response, err, unstable);
`else
    modport master (output start, chal_a, chal_b,
                    input  ro_en, busy, resp_valid, response, err);
    modport slave  (input  start, chal_a, chal_b,
                    output ro_en, busy, resp_valid, response, err);
`endif
endinterface

// File: rtl/ro_puf_ctrl_edge_counter.sv
// Saturating edge counter for one selected oscillator; fed with a
// one-cycle pulse per synchronised rising edge.
module ro_edge_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_edge,
    input  logic             clear,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (cnt_en && osc_edge && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF measurement controller: per response bit, counts two
// challenge-selected oscillators over a fixed window and compares them.
// Optional macro PUF_MARGIN_EN adds parameter MARGIN and the unstable mask.
module ro_puf_ctrl
    import puf_pkg::*;
#(
    parameter int NUM_RO    = 32,
    parameter int SEL_W     = $clog2(NUM_RO),
    parameter int CNT_W     = 8,
    parameter int WINDOW    = 255,
    parameter int SETTLE    = 4,
    parameter int RESP_BITS = 8
`ifdef PUF_MARGIN_EN
    ,
    parameter int MARGIN    = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] osc_in,
    ro_puf_ctrl_if.slave      bus,
    output puf_state_e        state_dbg
);

    localparam int TMR_W = idx_w((WINDOW > SETTLE) ? WINDOW : SETTLE);
    localparam int K_W   = idx_w(RESP_BITS);

    // A shorter settle would let edges from the previous pair leak into the window.
    if (SETTLE < 3) begin : g_bad_settle
        $error("ro_puf_ctrl: SETTLE must be at least 3");
    end
    if ((NUM_RO < 4) || ((NUM_RO & (NUM_RO - 1)) != 0)) begin : g_bad_num_ro
        $error("ro_puf_ctrl: NUM_RO must be a power of two and >= 4");
    end

    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [NUM_RO-1:0] sync1, sync2, sync3;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    puf_state_e           state, next_state;
    logic [TMR_W-1:0]     timer;
    logic [K_W-1:0]       k;
    logic [SEL_W-1:0]     chal_a_q, chal_b_q, idx_a, idx_b;
    logic [CNT_W-1:0]     cnt_a, cnt_b;
    logic [RESP_BITS-1:0] shadow;
    logic                 err_acc;
    logic                 edge_a, edge_b, same_pair, cmp_bit;
    logic                 ro_en, busy, cnt_clear, cnt_en;

    // Pair index wraps naturally in SEL_W bits.
    assign idx_a     = chal_a_q + SEL_W'(k);
    assign idx_b     = chal_b_q + SEL_W'(k);
    assign edge_a    = sync2[idx_a] & ~sync3[idx_a];
    assign edge_b    = sync2[idx_b] & ~sync3[idx_b];
    assign same_pair = (idx_a == idx_b);
    assign cmp_bit   = !same_pair && (cnt_a > cnt_b);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk(clk), .rst_n(rst_int_n), .osc_edge(edge_a),
        .clear(cnt_clear), .cnt_en(cnt_en), .count(cnt_a)
    );
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk(clk), .rst_n(rst_int_n), .osc_edge(edge_b),
        .clear(cnt_clear), .cnt_en(cnt_en), .count(cnt_b)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (bus.start) next_state = ST_SETTLE;
            ST_SETTLE:  if (timer == TMR_W'(SETTLE - 1)) next_state = ST_COUNT;
            ST_COUNT:   if (timer == TMR_W'(WINDOW - 1)) next_state = ST_COMPARE;
            ST_COMPARE: next_state = (k == K_W'(RESP_BITS - 1)) ? ST_DONE : ST_SETTLE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ro_en     = 1'b0;
        busy      = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_SETTLE:  begin ro_en = 1'b1; busy = 1'b1; cnt_clear = 1'b1; end
            ST_COUNT:   begin ro_en = 1'b1; busy = 1'b1; cnt_en = 1'b1; end
            ST_COMPARE: begin ro_en = 1'b1; busy = 1'b1; end
            ST_DONE:    busy = 1'b1;
            default:    ;
        endcase
    end

    assign bus.ro_en = ro_en;
    assign bus.busy  = busy;
    assign state_dbg = state;

`ifdef PUF_MARGIN_EN
    logic [RESP_BITS-1:0] unst_shadow;
    logic [CNT_W-1:0]     diff;
    logic                 unst_bit;

    assign diff     = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
    assign unst_bit = (32'(diff) < 32'(MARGIN));

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            unst_shadow  <= '0;
            bus.unstable <= '0;
        end else if (state == ST_COMPARE) begin
            unst_shadow  <= {unst_bit, unst_shadow} >> 1;
        end else if (state == ST_DONE) begin
            bus.unstable <= unst_shadow;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            timer          <= '0;
            k              <= '0;
            chal_a_q       <= '0;
            chal_b_q       <= '0;
            shadow         <= '0;
            err_acc        <= 1'b0;
            bus.response   <= '0;
            bus.err        <= 1'b0;
            bus.resp_valid <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            timer          <= (next_state != state) ? '0 : timer + 1'b1;
            case (state)
                ST_IDLE: if (bus.start) begin
                    chal_a_q <= bus.chal_a;
                    chal_b_q <= bus.chal_b;
                    k        <= '0;
                    err_acc  <= 1'b0;
                    shadow   <= '0;
                end
                ST_COMPARE: begin
                    // LSB-first: after RESP_BITS shifts the first pair sits in bit 0.
                    shadow  <= RESP_BITS'({cmp_bit, shadow} >> 1);
                    err_acc <= err_acc | same_pair;
                    k       <= k + 1'b1;
                end
                ST_DONE: begin
                    bus.response   <= shadow;
                    bus.err        <= err_acc;
                    bus.resp_valid <= 1'b1;
                    k              <= '0;
                    err_acc        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
